// File: rtl/pmod_da2_serializer_pkg.sv
// ----------------------------------------------------------------------------
// da2_pkg
//
// Shared definitions for the Pmod DA2 serializer slice.
//
// Contents:
//   FRAME_BITS / DATA_BITS  - DAC121S101 frame and code widths
//   PD_*                    - power-down field encodings (frame bits [13:12])
//   state_t / ST_*          - frame engine state encoding
//   make_frame()            - builds the 16-bit word {2'b00, pd, code}
// ----------------------------------------------------------------------------
package da2_pkg;

    // One DAC121S101 frame is 16 bits, of which the low 12 carry the code.
    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;

    // Power-down field values. Anything other than PD_NORMAL parks the
    // DAC output in the named termination.
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    // Frame engine states kept as plain constants so the encoding stays
    // stable for older tools and waveform viewers that key on it.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_STOP  = 2'd2;

    // Two leading don't-care zeros, the power-down field, then the code,
    // transmitted MSB first.
    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [1:0]           pd,
        input logic [DATA_BITS-1:0] code
    );
        return {2'b00, pd, code};
    endfunction

endpackage

// File: rtl/pmod_da2_serializer_if.sv
// ----------------------------------------------------------------------------
// pmod_da2_serializer_if
//
// Sample-side handshake between the audio control block and the DA2
// serializer.
//
// Signals:
//   start  - sample request, level sensitive while the serializer is idle
//   data1  - channel A code (unsigned, 12 bits)
//   data2  - channel B code (unsigned, 12 bits)
//   busy   - high while a frame is being sent
//   done   - one-cycle pulse at the end of each completed frame
//
// Modports:
//   master - the producer of samples (drives start/data, watches busy/done)
//   slave  - the serializer itself
// ----------------------------------------------------------------------------
interface pmod_da2_serializer_if;
    import da2_pkg::*;

    logic                 start;
    logic [DATA_BITS-1:0] data1;
    logic [DATA_BITS-1:0] data2;
    logic                 busy;
    logic                 done;

    modport master (
        output start,
        output data1,
        output data2,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data1,
        input  data2,
        output busy,
        output done
    );

endinterface

// File: rtl/pmod_da2_serializer_sclk_tick_gen.sv
// ----------------------------------------------------------------------------
// sclk_tick_gen
//
// Clock-enable generator for the DA2 serial clock. Emits a single-cycle
// tick every CLK_DIV system clocks; the frame engine toggles SCLK on each
// tick, so CLK_DIV is the SCLK half-period.
//
// Ports:
//   clock  - system clock, rising-edge active
//   reset  - asynchronous, active-high reset
//   clear  - synchronous restart; the next tick arrives CLK_DIV cycles later
//   tick   - high for one cycle every CLK_DIV cycles
// ----------------------------------------------------------------------------
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    // A divide-by-one still needs a one-bit counter to keep widths legal.
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    // The tick is decoded from the counter's terminal value, so after a
    // clear the counter sits at zero and the first tick lands exactly
    // CLK_DIV edges later. With CLK_DIV=1 the terminal value is zero and
    // the tick is simply always high.
    assign tick = (count == LAST);

    // Free-running modulo-CLK_DIV counter with a synchronous restart used
    // to align SCLK to the frame start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pmod_da2_serializer.sv
// ----------------------------------------------------------------------------
// pmod_da2_serializer
//
// Frame engine for the Pmod DA2 (two DAC121S101 channels sharing SCLK and
// nSYNC). A sample request latches both 12-bit codes, then both 16-bit
// frames are shifted out MSB first in lockstep. SCLK is produced from the
// system clock through a clock enable; there is no second clock domain.
//
// Parameters:
//   CLK_DIV  - SCLK half-period in system clocks (>= 1)
//   PD_MODE  - power-down field placed in frame bits [13:12]
//
// Ports:
//   clock     - system clock, rising-edge active
//   reset     - asynchronous, active-high reset
//   bus       - sample handshake (start, data1, data2, busy, done)
//   d1        - serial data to DAC A
//   d2        - serial data to DAC B
//   sclk_out  - serial clock to both DACs (idles high)
//   nsync     - frame select, active low
//
// Frame timing, counted in cycles after the edge that accepts start:
//   cycle 1                 nsync low, bit 15 on d1/d2, sclk high
//   cycle 1+CLK_DIV*(2k-1)  falling SCLK edge k (DAC samples), k = 1..16
//   cycle 1+CLK_DIV*2k      rising SCLK edge, next bit presented
//   cycle 1+32*CLK_DIV      nsync high, sclk held high
//   cycle 1+33*CLK_DIV      idle again, done pulses, busy drops
// ----------------------------------------------------------------------------
module pmod_da2_serializer
    import da2_pkg::*;
#(
    parameter int         CLK_DIV = 2,
    parameter logic [1:0] PD_MODE = PD_NORMAL
) (
    input  logic                        clock,
    input  logic                        reset,
    pmod_da2_serializer_if.slave        bus,
    output logic                        d1,
    output logic                        d2,
    output logic                        sclk_out,
    output logic                        nsync
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_t                state;
    logic [FRAME_BITS-1:0] shift1;
    logic [FRAME_BITS-1:0] shift2;
    logic [3:0]            bit_count;
    logic                  sclk_q;
    logic                  nsync_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  accept;
    logic                  tick;

    // A request is only honoured while idle; anything arriving mid-frame is
    // dropped rather than queued.
    assign accept = (state == ST_IDLE) && bus.start;

    // The tick generator is restarted on the accept edge so the first SCLK
    // falling edge sits a full half-period after nsync goes low.
    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    // The data lines are the MSBs of the shift registers, so they are
    // registered and simply hold their last bit while idle.
    assign d1       = shift1[FRAME_BITS-1];
    assign d2       = shift2[FRAME_BITS-1];
    assign sclk_out = sclk_q;
    assign nsync    = nsync_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Frame engine. Each tick toggles SCLK; on a falling toggle the DACs
    // sample the bit already on the line, and on the following rising
    // toggle the next bit is shifted up, which keeps each bit stable for a
    // full SCLK period centred on its falling edge. After the sixteenth
    // falling edge the rising toggle closes the frame instead, and the STOP
    // state holds nsync high for one more half-period as the minimum gap
    // before the engine reports completion and can accept again.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift1    <= '0;
            shift2    <= '0;
            bit_count <= '0;
            sclk_q    <= 1'b1;
            nsync_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sclk_q  <= 1'b1;
                    nsync_q <= 1'b1;
                    if (bus.start) begin
                        shift1    <= make_frame(PD_MODE, bus.data1);
                        shift2    <= make_frame(PD_MODE, bus.data2);
                        bit_count <= '0;
                        nsync_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (tick) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                        end else begin
                            sclk_q <= 1'b1;
                            if (bit_count == LAST_BIT) begin
                                nsync_q <= 1'b1;
                                state   <= ST_STOP;
                            end else begin
                                shift1    <= {shift1[FRAME_BITS-2:0], 1'b0};
                                shift2    <= {shift2[FRAME_BITS-2:0], 1'b0};
                                bit_count <= bit_count + 1'b1;
                            end
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end

                default: begin
                    sclk_q  <= 1'b1;
                    nsync_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pmod_da2_serializer.md
Name: pmod_da2_serializer

Overview:
- Downstream stage of the audio control block: takes two 12-bit DAC codes plus a sample strobe and serializes them to the Pmod DA2 (two DAC121S101 channels) over a shared SCLK/nSYNC pair.
- Runs entirely on the system clock and generates SCLK internally with a clock enable. No derived clock domains.
- Replaces the free-running clock-pair driver with a strobe-driven, handshaked frame engine.

Parameters:
- CLK_DIV, 2, SCLK half-period in system clock cycles. Legal range is ≥1. At 100 MHz, 2 gives 25 MHz SCLK.
- PD_MODE, 2'b00, DAC power-down bits sent in frame bits [13:12]. 00 is normal operation.

Ports:
- clock  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- start  in  1  sample request; sampled only in IDLE
- data1  in  12  channel A code, unsigned
- data2  in  12  channel B code, unsigned
- d1  out  1  serial data, DAC A
- d2  out  1  serial data, DAC B
- sclk_out  out  1  serial clock to both DACs
- nsync  out  1  frame select, active low
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, any time including mid-frame):
  - nsync=1, sclk_out=1, d1=0, d2=0, busy=0, done=0, state=IDLE, counters=0.
  - No done pulse is produced for an aborted frame.
- Frame format, per channel, MSB first: {2'b00, PD_MODE, data[11:0]}, 16 bits. The DAC samples on the falling edge of sclk_out.
- States: IDLE, SHIFT, STOP.
- IDLE:
  - sclk_out=1, nsync=1, d1/d2 hold their last value.
  - If start=1 at edge 0: latch both frame words into shift registers; set nsync<=0, busy<=1; drive d1/d2 with bit 15; clear the half-period counter and bit counter; go to SHIFT.
- SHIFT:
  - sclk_out toggles every CLK_DIV cycles.
  - Falling edge k (k=1..16) occurs at cycle 1+CLK_DIV*(2k-1).
  - On each rising toggle after falling edge k<16, d1/d2 advance to the next bit. Data stays stable for a full SCLK period around each falling edge.
  - On the rising toggle after falling edge 16 (cycle 1+32*CLK_DIV): nsync<=1, sclk_out stays 1, go to STOP.
- STOP:
  - Holds nsync high for CLK_DIV cycles as the minimum inter-frame gap.
  - At cycle 1+33*CLK_DIV: go to IDLE, busy<=0, done<=1 for exactly one cycle.
- Start handling:
  - start is level-sensitive in IDLE. It is accepted in any IDLE cycle, including the cycle where done=1.
  - start held high therefore produces back-to-back frames with period 1+33*CLK_DIV cycles.
  - start while busy=1 is ignored, with no queuing.
- data1/data2 are captured only at the accept edge. Changes during a frame have no effect on that frame.
- Both channels shift in lockstep on identical SCLK edges.
- All outputs are registered.

Decomposition:
- Shared package (da2_pkg):
  - FRAME_BITS=16
  - DATA_BITS=12
  - PD constants: PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_HIZ=2'b11
  - state enum {IDLE, SHIFT, STOP}
- One natural sub-module: sclk_tick_gen.
  - Parameterised by CLK_DIV.
  - Cleared synchronously by the FSM at frame start.
  - Emits a one-cycle tick every CLK_DIV cycles.
  - The FSM uses the tick to toggle sclk_out and to advance bits.

Test Plan:
- Reset, then a one-cycle start with CLK_DIV=2, data1=12'hA5C, data2=12'h3F0 -> nsync low at cycle 1; 16 falling SCLK edges capture d1=0000_1010_0101_1100 and d2=0000_0011_1111_0000; nsync high at cycle 65; done pulse at cycle 67; busy high for cycles 1..66.
- start held high for 3 frames with CLK_DIV=1 -> frames begin at cycles 1, 35, 69; nsync stays high for ≥1 cycle between frames; exactly 3 done pulses.
- Second start pulse issued at cycle 20, mid-frame -> ignored, one frame only; data1 changed at cycle 10 -> transmitted word unchanged.
- Reset asserted at cycle 30 of a frame -> same-cycle nsync=1, sclk_out=1, busy=0; no done pulse; a new start afterwards sends a clean full frame.
- PD_MODE=2'b11 with data1=12'hFFF -> serial word 0011_1111_1111_1111 on d1.
- Boundary codes data1=12'h000 and data2=12'hFFF -> exact bit patterns on both lines; bit 15 is present on d1/d2 before the first falling edge.
